// File: rtl/mem_stage_pkg.sv
// mem_stage_pkg: load encodings, PC reset value and the execute-to-memory payload layout
package mem_stage_pkg;
    localparam logic [2:0] LD_W  = 3'b000;
    localparam logic [2:0] LD_B  = 3'b001;
    localparam logic [2:0] LD_H  = 3'b010;
    localparam logic [2:0] LD_BU = 3'b011;
    localparam logic [2:0] LD_HU = 3'b100;
    localparam logic [31:0] PC_RESET_VAL = 32'h1bfffffc;
    localparam int EX_MEM_W = 103;
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] alu_result;
        logic        res_from_mem;
        logic        reg_en;
        logic [4:0]  dest;
    } ex_mem_t;
    function automatic ex_mem_t ex_mem_reset(logic [31:0] pc);
        ex_mem_t p;
        p = ex_mem_t'({EX_MEM_W{1'b0}});
        p.pc = pc;
        return p;
    endfunction
endpackage

// File: rtl/mem_stage_if.sv
// mem_stage_if: execute-side, SRAM and write-back-side signals of the memory stage
interface mem_stage_if;
    logic        ready_go_ex;
    logic        allow_in;
    logic [31:0] inst_from_ex;
    logic [31:0] pc_from_ex;
    logic [31:0] alu_result_from_ex;
    logic        res_from_mem_from_ex;
    logic [2:0]  ld_op_from_ex;
    logic        reg_en_from_ex;
    logic [4:0]  dest_from_ex;
    logic [31:0] data_sram_rdata;
    logic        ready_go_mem;
    logic        allow_in_wb;
    logic [31:0] inst_to_wb;
    logic [31:0] pc_to_wb;
    logic [31:0] data_to_reg;
    logic        reg_en_to_wb;
    logic [4:0]  dest_to_wb;
    logic        valid;
    logic [31:0] forward_data_mem;
    logic        fwd_we_mem;
    logic [4:0]  fwd_dest_mem;
    modport slave (
        input  ready_go_ex, inst_from_ex, pc_from_ex, alu_result_from_ex, res_from_mem_from_ex,
               ld_op_from_ex, reg_en_from_ex, dest_from_ex, data_sram_rdata, allow_in_wb,
        output allow_in, ready_go_mem, inst_to_wb, pc_to_wb, data_to_reg, reg_en_to_wb,
               dest_to_wb, valid, forward_data_mem, fwd_we_mem, fwd_dest_mem
    );
    modport master (
        output ready_go_ex, inst_from_ex, pc_from_ex, alu_result_from_ex, res_from_mem_from_ex,
               ld_op_from_ex, reg_en_from_ex, dest_from_ex, data_sram_rdata, allow_in_wb,
        input  allow_in, ready_go_mem, inst_to_wb, pc_to_wb, data_to_reg, reg_en_to_wb,
               dest_to_wb, valid, forward_data_mem, fwd_we_mem, fwd_dest_mem
    );
endinterface

// File: rtl/mem_stage_load_align.sv
// load_align: byte/halfword lane selection and extension of a 32-bit read word
module load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  addr,
    input  logic [2:0]  ld_op,
    output logic [31:0] result
);
    logic [7:0]  lane_b;
    logic [15:0] lane_h;
    always_comb begin
        lane_b = addr[1] ? (addr[0] ? rdata[31:24] : rdata[23:16])
                         : (addr[0] ? rdata[15:8]  : rdata[7:0]);
        lane_h = addr[1] ? rdata[31:16] : rdata[15:0];
        result = (ld_op == LD_B)  ? {{24{lane_b[7]}}, lane_b} :
                 (ld_op == LD_BU) ? {24'd0, lane_b} :
                 (ld_op == LD_H)  ? {{16{lane_h[15]}}, lane_h} :
                 (ld_op == LD_HU) ? {16'd0, lane_h} : rdata;
    end
endmodule

// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage with load extraction and a stall read-data buffer
// Sub-word load extraction is enabled by defining MEM_SUBWORD_LD_EN.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter logic [31:0] PC_RESET = PC_RESET_VAL
) (
    input logic        clk,
    input logic        resetn,
    mem_stage_if.slave bus
);
    ex_mem_t     pl;
    logic        valid;
    logic        rbuf_vld;
    logic [31:0] rbuf;
    logic [31:0] rdata;
    logic [31:0] load_result;
    logic [31:0] result;
    logic        allow_in;
`ifdef MEM_SUBWORD_LD_EN
    logic [2:0]  ld_op;
`endif
    assign allow_in = !valid | (valid & bus.allow_in_wb);
    always_ff @(posedge clk) begin
        if (!resetn) begin
            valid    <= 1'b0;
            pl       <= ex_mem_reset(PC_RESET);
            rbuf     <= 32'd0;
            rbuf_vld <= 1'b0;
`ifdef MEM_SUBWORD_LD_EN
            ld_op    <= LD_W;
`endif
        end else begin
            if (allow_in) valid <= bus.ready_go_ex;
            if (allow_in & bus.ready_go_ex) begin
                pl <= '{inst: bus.inst_from_ex, pc: bus.pc_from_ex,
                        alu_result: bus.alu_result_from_ex, res_from_mem: bus.res_from_mem_from_ex,
                        reg_en: bus.reg_en_from_ex, dest: bus.dest_from_ex};
`ifdef MEM_SUBWORD_LD_EN
                ld_op <= bus.ld_op_from_ex;
`endif
            end
            // SRAM data is only valid in the first resident cycle; hold it for later stall cycles
            if (allow_in) rbuf_vld <= 1'b0;
            else if (valid & !rbuf_vld & !bus.allow_in_wb) begin
                rbuf     <= bus.data_sram_rdata;
                rbuf_vld <= 1'b1;
            end
        end
    end
    assign rdata = rbuf_vld ? rbuf : bus.data_sram_rdata;
`ifdef MEM_SUBWORD_LD_EN
    load_align u_load_align (
        .rdata  (rdata),
        .addr   (pl.alu_result[1:0]),
        .ld_op  (ld_op),
        .result (load_result)
    );
`else
    assign load_result = rdata;
`endif
    assign result               = pl.res_from_mem ? load_result : pl.alu_result;
    assign bus.allow_in         = allow_in;
    assign bus.ready_go_mem     = valid;
    assign bus.valid            = valid;
    assign bus.inst_to_wb       = pl.inst;
    assign bus.pc_to_wb         = pl.pc;
    assign bus.data_to_reg      = result;
    assign bus.reg_en_to_wb     = pl.reg_en;
    assign bus.dest_to_wb       = pl.dest;
    assign bus.forward_data_mem = result;
    assign bus.fwd_we_mem       = valid & pl.reg_en;
    assign bus.fwd_dest_mem     = pl.dest;
endmodule
